multdiv_issue_ctrl: RTL and testbench

//  Requester-side controller for the iterative multdiv unit. Accepts one MUL/DIV op from the

---
 rtl/multdiv_issue_ctrl_if.sv | 37 +++
 rtl/multdiv_issue_ctrl.sv | 113 +++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_issue_ctrl_if.sv
// Handshake bundle between the execute stage, the issue controller and the multdiv unit.
// The slave view is the controller; the master view is everything around it.
interface multdiv_issue_ctrl_if;
    logic        issue_valid;
    logic        issue_is_div;
    logic [31:0] issue_opA;
    logic [31:0] issue_opB;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        flush;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_exception;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd, flush,
               data_result, data_exception, data_resultRDY,
        input  issue_ready, stall, wb_valid, wb_data, wb_rd, wb_exception,
               ctrl_MULT, ctrl_DIV, data_operandA, data_operandB
    );

    modport slave (
        input  issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd, flush,
               data_result, data_exception, data_resultRDY,
        output issue_ready, stall, wb_valid, wb_data, wb_rd, wb_exception,
               ctrl_MULT, ctrl_DIV, data_operandA, data_operandB
    );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the iterative multdiv unit: accepts one op, pulses the start strobe,
// waits for the result (or times out) and returns it as a one-cycle writeback.
module multdiv_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input logic                 clock,
    input logic                 reset_n,
    multdiv_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      opa_q, opb_q, wb_data_q;
    logic [4:0]       rd_q, wb_rd_q;
    logic             is_div_q;
    logic             ready_q, stall_q, wb_valid_q, wb_exc_q, mult_q, div_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            rd_q       <= '0;
            is_div_q   <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_exc_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            stall_q    <= 1'b0;
            mult_q     <= 1'b0;
            div_q      <= 1'b0;
        end else begin
            // Strobes default low so each is high for exactly one state.
            mult_q     <= 1'b0;
            div_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.issue_valid) begin
                        opa_q    <= bus.issue_opA;
                        opb_q    <= bus.issue_opB;
                        rd_q     <= bus.issue_rd;
                        is_div_q <= bus.issue_is_div;
                        mult_q   <= ~bus.issue_is_div;
                        div_q    <= bus.issue_is_div;
                        ready_q  <= 1'b0;
                        stall_q  <= 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    cnt_q <= '0;
                    if (bus.flush) begin
                        ready_q <= 1'b1;
                        stall_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
                    // Flush wins over a result arriving in the same cycle.
                    if (bus.flush) begin
                        ready_q <= 1'b1;
                        stall_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (bus.data_resultRDY) begin
                        wb_data_q  <= bus.data_result;
                        wb_exc_q   <= bus.data_exception;
                        wb_rd_q    <= rd_q;
                        wb_valid_q <= 1'b1;
                        state_q    <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        wb_data_q  <= '0;
                        wb_exc_q   <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_valid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    stall_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.issue_ready   = ready_q;
    assign bus.stall         = stall_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_exception  = wb_exc_q;
    assign bus.ctrl_MULT     = mult_q;
    assign bus.ctrl_DIV      = div_q;
    assign bus.data_operandA = opa_q;
    assign bus.data_operandB = opb_q;

    // The op type is only needed to steer the start strobe.
    logic unused_is_div;
    assign unused_is_div = is_div_q;
endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl; the bench plays both the execute stage and multdiv.
module tb_multdiv_issue_ctrl;
    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    multdiv_issue_ctrl_if bus ();

    multdiv_issue_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Full op: accept in current IDLE cycle, RDY on BUSY cycle n, walk through writeback.
    task automatic do_op(input string tag, input logic div, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int n, input logic [31:0] res, input logic exc);
        int strobes;
        int unstable;
        int early_wb;
        bus.issue_valid  = 1'b1;
        bus.issue_is_div = div;
        bus.issue_opA    = a;
        bus.issue_opB    = b;
        bus.issue_rd     = rd;
        tick;
        bus.issue_valid  = 1'b0;
        bus.issue_opA    = 32'hDEAD_BEEF;
        bus.issue_opB    = 32'h1234_5678;
        bus.issue_rd     = 5'd31;
        chk({tag, " ctrl_MULT"}, {31'd0, bus.ctrl_MULT}, {31'd0, ~div});
        chk({tag, " ctrl_DIV"}, {31'd0, bus.ctrl_DIV}, {31'd0, div});
        chk({tag, " stall_start"}, {31'd0, bus.stall}, 32'd1);
        chk({tag, " ready_start"}, {31'd0, bus.issue_ready}, 32'd0);
        strobes = 0; unstable = 0; early_wb = 0;
        for (int k = 1; k <= n; k++) begin
            tick;
            if (bus.ctrl_MULT || bus.ctrl_DIV) strobes++;
            if (bus.data_operandA !== a || bus.data_operandB !== b || bus.stall !== 1'b1) unstable++;
            if (bus.wb_valid !== 1'b0) early_wb++;
            if (k == n) begin
                bus.data_resultRDY = 1'b1;
                bus.data_result    = res;
                bus.data_exception = exc;
            end
        end
        chk({tag, " extra_strobes"}, strobes, 0);
        chk({tag, " busy_unstable"}, unstable, 0);
        chk({tag, " early_wb"}, early_wb, 0);
        tick;
        bus.data_resultRDY = 1'b0;
        bus.data_result    = 32'h0BAD_0BAD;
        bus.data_exception = 1'b0;
        chk({tag, " wb_valid"}, {31'd0, bus.wb_valid}, 32'd1);
        chk({tag, " wb_data"}, bus.wb_data, res);
        chk({tag, " wb_rd"}, {27'd0, bus.wb_rd}, {27'd0, rd});
        chk({tag, " wb_exception"}, {31'd0, bus.wb_exception}, {31'd0, exc});
        chk({tag, " stall_done"}, {31'd0, bus.stall}, 32'd1);
        tick;
        chk({tag, " wb_valid_low"}, {31'd0, bus.wb_valid}, 32'd0);
        chk({tag, " stall_idle"}, {31'd0, bus.stall}, 32'd0);
        chk({tag, " ready_idle"}, {31'd0, bus.issue_ready}, 32'd1);
        chk({tag, " wb_data_hold"}, bus.wb_data, res);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst ready", {31'd0, bus.issue_ready}, 32'd1);
        chk("rst stall", {31'd0, bus.stall}, 32'd0);
        chk("rst wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst ctrl", {30'd0, bus.ctrl_MULT, bus.ctrl_DIV}, 32'd0);
        chk("rst opA", bus.data_operandA, 32'd0);
        chk("rst wb_data", bus.wb_data, 32'd0);
        reset_n = 1'b1;
        tick;
        chk("rst release ready", {31'd0, bus.issue_ready}, 32'd1);
    endtask

    task automatic test_mul;
        do_op("mul", 1'b0, 32'd6, 32'd7, 5'd5, 16, 32'd42, 1'b0);
    endtask

    task automatic test_div;
        do_op("div", 1'b1, 32'hFFFF_FFEC, 32'd3, 5'd9, 5, 32'hFFFF_FFFA, 1'b0);
        do_op("div0", 1'b1, 32'd5, 32'd0, 5'd3, 2, 32'd0, 1'b1);
    endtask

    task automatic test_timeout;
        int k;
        bus.issue_valid = 1'b1; bus.issue_is_div = 1'b1;
        bus.issue_opA = 32'd8; bus.issue_opB = 32'd2; bus.issue_rd = 5'd12;
        tick;
        bus.issue_valid = 1'b0;
        bus.data_resultRDY = 1'b1; bus.data_result = 32'h1234; bus.data_exception = 1'b0;
        tick;
        bus.data_resultRDY = 1'b0;
        k = 1;
        while (bus.wb_valid !== 1'b1 && k < 100) begin
            tick;
            k++;
        end
        chk("timeout cycles", k, 65);
        chk("timeout wb_data", bus.wb_data, 32'd0);
        chk("timeout wb_exc", {31'd0, bus.wb_exception}, 32'd1);
        chk("timeout wb_rd", {27'd0, bus.wb_rd}, 32'd12);
        tick;
        chk("timeout ready", {31'd0, bus.issue_ready}, 32'd1);
    endtask

    task automatic test_flush;
        bus.issue_valid = 1'b1; bus.issue_is_div = 1'b0;
        bus.issue_opA = 32'd3; bus.issue_opB = 32'd4; bus.issue_rd = 5'd7;
        tick;
        bus.issue_valid = 1'b0;
        repeat (3) tick;
        // BUSY cycle 3: flush together with a result; flush must win.
        bus.flush = 1'b1;
        bus.data_resultRDY = 1'b1; bus.data_result = 32'd12;
        tick;
        bus.flush = 1'b0;
        bus.data_resultRDY = 1'b0;
        chk("flush wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("flush stall", {31'd0, bus.stall}, 32'd0);
        chk("flush ready", {31'd0, bus.issue_ready}, 32'd1);
        do_op("post_flush", 1'b1, 32'd100, 32'd10, 5'd2, 3, 32'd10, 1'b0);
    endtask

    task automatic test_flush_idle_done;
        bus.flush = 1'b1;
        bus.issue_valid = 1'b1; bus.issue_is_div = 1'b0;
        bus.issue_opA = 32'd11; bus.issue_opB = 32'd7; bus.issue_rd = 5'd20;
        tick;
        bus.flush = 1'b0;
        bus.issue_valid = 1'b0;
        chk("idle_flush accepted", {31'd0, bus.ctrl_MULT}, 32'd1);
        tick;
        bus.data_resultRDY = 1'b1; bus.data_result = 32'd77;
        tick;
        bus.data_resultRDY = 1'b0;
        bus.flush = 1'b1;
        chk("done_flush wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("done_flush wb_data", bus.wb_data, 32'd77);
        tick;
        bus.flush = 1'b0;
        chk("done_flush ready", {31'd0, bus.issue_ready}, 32'd1);
    endtask

    task automatic test_back_to_back;
        bus.issue_valid = 1'b1; bus.issue_is_div = 1'b0;
        bus.issue_opA = 32'd2; bus.issue_opB = 32'd3; bus.issue_rd = 5'd1;
        tick;
        bus.issue_valid = 1'b0;
        tick;
        bus.data_resultRDY = 1'b1; bus.data_result = 32'd6;
        bus.issue_valid = 1'b1; bus.issue_is_div = 1'b1;
        bus.issue_opA = 32'd9; bus.issue_opB = 32'd3; bus.issue_rd = 5'd4;
        tick;
        bus.data_resultRDY = 1'b0;
        chk("b2b done ready", {31'd0, bus.issue_ready}, 32'd0);
        chk("b2b done wb_data", bus.wb_data, 32'd6);
        tick;
        chk("b2b idle no strobe", {30'd0, bus.ctrl_MULT, bus.ctrl_DIV}, 32'd0);
        chk("b2b idle ready", {31'd0, bus.issue_ready}, 32'd1);
        tick;
        bus.issue_valid = 1'b0;
        chk("b2b start ctrl_DIV", {31'd0, bus.ctrl_DIV}, 32'd1);
        chk("b2b start opA", bus.data_operandA, 32'd9);
        tick;
        bus.data_resultRDY = 1'b1; bus.data_result = 32'd3;
        tick;
        bus.data_resultRDY = 1'b0;
        chk("b2b wb_data", bus.wb_data, 32'd3);
        chk("b2b wb_rd", {27'd0, bus.wb_rd}, 32'd4);
        tick;
    endtask

    task automatic test_async_reset;
        bus.issue_valid = 1'b1; bus.issue_is_div = 1'b0;
        bus.issue_opA = 32'd5; bus.issue_opB = 32'd5; bus.issue_rd = 5'd6;
        tick;
        bus.issue_valid = 1'b0;
        repeat (4) tick;
        #2 reset_n = 1'b0;
        #1;
        chk("async stall", {31'd0, bus.stall}, 32'd0);
        chk("async opA", bus.data_operandA, 32'd0);
        chk("async ready", {31'd0, bus.issue_ready}, 32'd1);
        #1 reset_n = 1'b1;
        tick;
        chk("async release ready", {31'd0, bus.issue_ready}, 32'd1);
        chk("async release wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        do_op("post_reset", 1'b0, 32'd9, 32'd9, 5'd8, 1, 32'd81, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.issue_valid = 1'b0; bus.issue_is_div = 1'b0;
        bus.issue_opA = '0; bus.issue_opB = '0; bus.issue_rd = '0;
        bus.flush = 1'b0;
        bus.data_result = '0; bus.data_exception = 1'b0; bus.data_resultRDY = 1'b0;
        test_reset;
        test_mul;
        test_div;
        test_timeout;
        test_flush;
        test_flush_idle_done;
        test_back_to_back;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
